// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: select encodings and the
// in-flight pipeline entry record.
package fwd_pkg;

    localparam int SEL_REGFILE   = 0;
    localparam int SEL_STAGE_EX  = 1;
    localparam int SEL_STAGE_MEM = 2;

    // Destination field is sized for the widest supported register file;
    // narrower addresses are zero-extended on entry.
    localparam int ENTRY_AW_MAX = 8;

    typedef struct packed {
        logic                    valid;
        logic [ENTRY_AW_MAX-1:0] dest;
        logic                    is_ld;
    } fwd_entry_t;

    function automatic int sel_width(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and forwarding/stall response bundle.
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int REG_AW     = 3,
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = sel_width(NUM_STAGES);

    logic              frwd_en;
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_is_st;
    logic [REG_AW-1:0] id_dest;
    logic              id_wb_en;
    logic              id_is_ld;
    logic              flush;
    logic [SEL_W-1:0]  frwd_op1_sel;
    logic [SEL_W-1:0]  frwd_op2_sel;
    logic [SEL_W-1:0]  frwd_store_sel;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output frwd_en, id_valid, id_src1, id_src2, id_is_st,
               id_dest, id_wb_en, id_is_ld, flush,
        input  frwd_op1_sel, frwd_op2_sel, frwd_store_sel, stall, stall_cnt
    );

    modport slave (
        input  frwd_en, id_valid, id_src1, id_src2, id_is_st,
               id_dest, id_wb_en, id_is_ld, flush,
        output frwd_op1_sel, frwd_op2_sel, frwd_store_sel, stall, stall_cnt
    );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// Compares one ID source register against every in-flight entry and reports
// the nearest producing stage plus whether that producer is an EX-stage load.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW     = 3,
    parameter int NUM_STAGES = 2,
    parameter int SEL_W      = 2
) (
    input  fwd_entry_t        entries_i [1:NUM_STAGES],
    input  logic [REG_AW-1:0] src_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic              hit_o,
    output logic              ld_hit_o
);

    logic [ENTRY_AW_MAX-1:0] src_ext_s;

    assign src_ext_s = ENTRY_AW_MAX'(src_i);

    // Walk from the oldest stage down so the youngest (lowest index) match wins.
    always_comb begin
        sel_o    = '0;
        hit_o    = 1'b0;
        ld_hit_o = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (entries_i[k].valid && (entries_i[k].dest != '0) &&
                (entries_i[k].dest == src_ext_s)) begin
                sel_o    = SEL_W'(k);
                hit_o    = 1'b1;
                ld_hit_o = (k == SEL_STAGE_EX) && entries_i[k].is_ld;
            end else begin
                sel_o    = sel_o;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use / interlock stall generation for the
// ID stage, tracking NUM_STAGES non-stalling stages behind it.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW     = 3,
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    fwd_hazard_unit_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_STAGES);

    fwd_entry_t       entry_q [1:NUM_STAGES];
    fwd_entry_t       entry_d [1:NUM_STAGES];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic [SEL_W-1:0] sel1_s, sel2_s;
    logic             hit1_s, hit2_s, ld1_s, ld2_s;
    logic             active_s, stall_s;
    logic [SEL_W-1:0] op1_sel_s, op2_sel_s, store_sel_s;

    fwd_match #(.REG_AW(REG_AW), .NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_match_src1 (
        .entries_i(entry_q), .src_i(bus.id_src1),
        .sel_o(sel1_s), .hit_o(hit1_s), .ld_hit_o(ld1_s)
    );

    fwd_match #(.REG_AW(REG_AW), .NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_match_src2 (
        .entries_i(entry_q), .src_i(bus.id_src2),
        .sel_o(sel2_s), .hit_o(hit2_s), .ld_hit_o(ld2_s)
    );

    // Stall and select decode; any stall forces every select back to the regfile.
    always_comb begin
        active_s    = bus.id_valid & ~bus.flush;
        stall_s     = 1'b0;
        op1_sel_s   = '0;
        op2_sel_s   = '0;
        store_sel_s = '0;
        if (!active_s) begin
            stall_s = 1'b0;
        end else if (bus.frwd_en) begin
            stall_s = ld1_s | ld2_s;
            if (!stall_s) begin
                op1_sel_s = sel1_s;
                if (bus.id_is_st) begin
                    store_sel_s = sel2_s;
                end else begin
                    op2_sel_s = sel2_s;
                end
            end else begin
                op1_sel_s = '0;
            end
        end else begin
            stall_s = hit1_s | hit2_s;
        end
    end

    // Next-state of the in-flight tracker and the saturating stall counter.
    always_comb begin
        entry_d[1] = '0;
        if (active_s && !stall_s) begin
            entry_d[1].valid = bus.id_wb_en;
            entry_d[1].dest  = ENTRY_AW_MAX'(bus.id_dest);
            entry_d[1].is_ld = bus.id_is_ld;
        end else begin
            entry_d[1].valid = 1'b0;
        end
        for (int k = 2; k <= NUM_STAGES; k++) begin
            entry_d[k] = entry_q[k-1];
        end
        if (stall_s && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                entry_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                entry_q[k] <= entry_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall          = stall_s;
    assign bus.frwd_op1_sel   = op1_sel_s;
    assign bus.frwd_op2_sel   = op2_sel_s;
    assign bus.frwd_store_sel = store_sel_s;
    assign bus.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomized checks of fwd_hazard_unit against a reference model
// of the in-flight instruction list; a second instance uses a 2-bit counter.
module tb_fwd_hazard_unit;

    localparam int NS = 2;

    logic clk;
    logic rst;
    logic frwd_en, id_valid, id_is_st, id_wb_en, id_is_ld, flush;
    logic [2:0] src1, src2, dest;

    int checks = 0;
    int errors = 0;

    // Reference model: what each stage holds, plus counters.
    logic       m_valid [1:NS];
    logic [2:0] m_dest  [1:NS];
    logic       m_ld    [1:NS];
    int         m_cnt1, m_cnt2;
    logic       e_stall;

    fwd_hazard_unit_if #(.REG_AW(3), .NUM_STAGES(NS), .CNT_W(16)) bus1 ();
    fwd_hazard_unit_if #(.REG_AW(3), .NUM_STAGES(NS), .CNT_W(2))  bus2 ();

    assign bus1.frwd_en = frwd_en;  assign bus2.frwd_en = frwd_en;
    assign bus1.id_valid = id_valid; assign bus2.id_valid = id_valid;
    assign bus1.id_src1 = src1;     assign bus2.id_src1 = src1;
    assign bus1.id_src2 = src2;     assign bus2.id_src2 = src2;
    assign bus1.id_is_st = id_is_st; assign bus2.id_is_st = id_is_st;
    assign bus1.id_dest = dest;     assign bus2.id_dest = dest;
    assign bus1.id_wb_en = id_wb_en; assign bus2.id_wb_en = id_wb_en;
    assign bus1.id_is_ld = id_is_ld; assign bus2.id_is_ld = id_is_ld;
    assign bus1.flush = flush;      assign bus2.flush = flush;

    fwd_hazard_unit #(.REG_AW(3), .NUM_STAGES(NS), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );
    fwd_hazard_unit #(.REG_AW(3), .NUM_STAGES(NS), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nearest(input logic [2:0] s);
        for (int k = 1; k <= NS; k++) begin
            if (m_valid[k] && m_dest[k] != 3'd0 && m_dest[k] == s) return k;
        end
        return 0;
    endfunction

    // Compare combinational outputs of both instances against the model.
    task automatic settle();
        int m1, m2, e1, e2, es;
        #3;
        m1 = nearest(src1);
        m2 = nearest(src2);
        e1 = 0; e2 = 0; es = 0; e_stall = 1'b0;
        if (id_valid && !flush) begin
            if (frwd_en) begin
                e_stall = (m1 == 1 && m_ld[1]) || (m2 == 1 && m_ld[1]);
                if (!e_stall) begin
                    e1 = m1;
                    if (id_is_st) es = m2; else e2 = m2;
                end
            end else begin
                e_stall = (m1 != 0) || (m2 != 0);
            end
        end
        chk("stall",     32'(bus1.stall),          32'(e_stall));
        chk("op1_sel",   32'(bus1.frwd_op1_sel),   32'(e1));
        chk("op2_sel",   32'(bus1.frwd_op2_sel),   32'(e2));
        chk("store_sel", 32'(bus1.frwd_store_sel), 32'(es));
        chk("stall_b",   32'(bus2.stall),          32'(e_stall));
        chk("op1_sel_b", 32'(bus2.frwd_op1_sel),   32'(e1));
    endtask

    // Clock edge: advance the model, then check the counters.
    task automatic tick();
        logic enter;
        enter = id_valid && !flush && !e_stall;
        @(posedge clk);
        if (rst) begin
            for (int k = 1; k <= NS; k++) m_valid[k] = 1'b0;
            m_cnt1 = 0;
            m_cnt2 = 0;
        end else begin
            for (int k = NS; k >= 2; k--) begin
                m_valid[k] = m_valid[k-1];
                m_dest[k]  = m_dest[k-1];
                m_ld[k]    = m_ld[k-1];
            end
            m_valid[1] = enter && id_wb_en;
            m_dest[1]  = dest;
            m_ld[1]    = id_is_ld;
            if (e_stall) begin
                if (m_cnt1 < 65535) m_cnt1++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        #1;
        chk("stall_cnt",   32'(bus1.stall_cnt), 32'(m_cnt1));
        chk("stall_cnt_b", 32'(bus2.stall_cnt), 32'(m_cnt2));
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic drive(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                         input logic st, input logic [2:0] d, input logic wb, input logic ld);
        id_valid = v; src1 = s1; src2 = s2; id_is_st = st;
        dest = d; id_wb_en = wb; id_is_ld = ld; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        frwd_en = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int k = 1; k <= NS; k++) begin
            m_valid[k] = 1'b0; m_dest[k] = 3'd0; m_ld[k] = 1'b0;
        end
        m_cnt1 = 0; m_cnt2 = 0; e_stall = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Write r3, then read it: EX forward; with a bubble between: MEM forward.
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0); cyc();
        drive(1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); settle();
        chk("dir_fwd_ex", 32'(bus1.frwd_op1_sel), 32'd1); tick();
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0); cyc();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); cyc();
        drive(1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); settle();
        chk("dir_fwd_mem", 32'(bus1.frwd_op1_sel), 32'd2); tick();

        // Load-use on src2.
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1); cyc();
        drive(1'b1, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0); settle();
        chk("dir_ldu_stall", 32'(bus1.stall), 32'd1); tick();
        chk("dir_ldu_cnt", 32'(bus1.stall_cnt), 32'd1);
        settle();
        chk("dir_ldu_after", 32'(bus1.frwd_op2_sel), 32'd2); tick();

        // Store data forwarding, and r0 never forwards.
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0); cyc();
        drive(1'b1, 3'd0, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0); settle();
        chk("dir_store_sel", 32'(bus1.frwd_store_sel), 32'd1);
        chk("dir_store_op2", 32'(bus1.frwd_op2_sel), 32'd0); tick();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0); cyc();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); settle();
        chk("dir_r0", 32'(bus1.frwd_op1_sel), 32'd0); tick();

        // Two writers of r6 in flight: the nearest wins.
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0); cyc(); cyc();
        drive(1'b1, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); settle();
        chk("dir_nearest", 32'(bus1.frwd_op1_sel), 32'd1); tick();

        // Interlock-only mode: stall until the writer leaves the tracker.
        do_reset();
        frwd_en = 1'b0;
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0); cyc();
        drive(1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        settle(); chk("dir_il_s1", 32'(bus1.stall), 32'd1); tick();
        settle(); chk("dir_il_s2", 32'(bus1.stall), 32'd1);
        chk("dir_il_sel", 32'(bus1.frwd_op1_sel), 32'd0); tick();
        settle(); chk("dir_il_s3", 32'(bus1.stall), 32'd0); tick();
        frwd_en = 1'b1;

        // Repeated self-dependent loads: counter saturation in the 2-bit instance.
        do_reset();
        drive(1'b1, 3'd5, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cyc();
        chk("dir_sat_b", 32'(bus2.stall_cnt), 32'd3);
        chk("dir_sat",   32'(bus1.stall_cnt), 32'd5);

        // Flush and reset while a load-use stall is pending.
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1); cyc();
        drive(1'b1, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0); flush = 1'b1; settle();
        chk("dir_flush", 32'(bus1.stall), 32'd0); tick();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1); cyc();
        drive(1'b1, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0); settle();
        chk("dir_rst_pre", 32'(bus1.stall), 32'd1);
        rst = 1'b1; tick();
        rst = 1'b0; settle();
        chk("dir_rst_post", 32'(bus1.stall), 32'd0); tick();

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0);
            flush   = ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0;
            rst     = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
            frwd_en = ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
